// File: rtl/ll_tx_framer.sv
// rtl/ll_tx_framer.sv - LocalLink TX framer: header + fixed-length payload frames with channel-loss flush
module ll_tx_framer #(
  parameter int PKT_WORDS = 94,
  parameter int DW        = 16
) (
  input  logic          clk_156m,
  input  logic          rst_n,
  input  logic          channel_up,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_sof_n,
  output logic          tx_eof_n,
  output logic          tx_src_rdy_n,
  input  logic          tx_dst_rdy_n,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_WORDS - 1);
  localparam logic [7:0] PKT_CNT  = 8'(PKT_WORDS);
  localparam logic [7:0] HDR_TAG  = 8'hA5;

  typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [7:0]    seq, seq_nxt;
  logic [7:0]    wcnt, wcnt_nxt;
  logic [DW-1:0] data_nxt;
  logic          sof_nxt, eof_nxt, src_nxt;
  logic [15:0]   frame_nxt, drop_nxt;
  logic          out_free;
  logic          in_frame;

  // Output register can take a new word when empty or its word is being taken this cycle.
  assign out_free = tx_src_rdy_n | ~tx_dst_rdy_n;
  assign in_frame = (state == PAYLOAD) || (state == TAIL);

  // Next-state and next-output logic; channel loss inside a frame overrides everything else.
  always_comb begin
    state_nxt = state;
    seq_nxt   = seq;
    wcnt_nxt  = wcnt;
    data_nxt  = tx_data;
    sof_nxt   = tx_sof_n;
    eof_nxt   = tx_eof_n;
    src_nxt   = tx_src_rdy_n;
    frame_nxt = frame_cnt;
    drop_nxt  = drop_cnt;
    s_ready   = 1'b0;

    if (in_frame && !channel_up) begin
      // Abort without eof; keep consuming upstream words so the next frame stays aligned.
      src_nxt   = 1'b1;
      drop_nxt  = drop_cnt + 16'd1;
      state_nxt = (wcnt < PKT_CNT) ? FLUSH : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (channel_up && s_valid && out_free) begin
            data_nxt  = {HDR_TAG, seq};
            sof_nxt   = 1'b0;
            eof_nxt   = 1'b1;
            src_nxt   = 1'b0;
            wcnt_nxt  = 8'd0;
            state_nxt = PAYLOAD;
          end else if (out_free) begin
            src_nxt = 1'b1;
          end
        end
        PAYLOAD: begin
          s_ready = out_free;
          if (s_valid && out_free) begin
            data_nxt = s_data;
            sof_nxt  = 1'b1;
            eof_nxt  = ~(wcnt == LAST_IDX);
            src_nxt  = 1'b0;
            wcnt_nxt = wcnt + 8'd1;
            if (wcnt == LAST_IDX) begin
              state_nxt = TAIL;
            end
          end else if (out_free) begin
            src_nxt = 1'b1;
          end
        end
        TAIL: begin
          if (!tx_dst_rdy_n) begin
            src_nxt   = 1'b1;
            seq_nxt   = seq + 8'd1;
            frame_nxt = frame_cnt + 16'd1;
            state_nxt = IDLE;
          end
        end
        FLUSH: begin
          s_ready = 1'b1;
          if (s_valid) begin
            wcnt_nxt = wcnt + 8'd1;
            if (wcnt == LAST_IDX) begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counters and the registered link outputs.
  always_ff @(posedge clk_156m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      seq          <= 8'd0;
      wcnt         <= 8'd0;
      tx_data      <= '0;
      tx_sof_n     <= 1'b1;
      tx_eof_n     <= 1'b1;
      tx_src_rdy_n <= 1'b1;
      frame_cnt    <= 16'd0;
      drop_cnt     <= 16'd0;
    end else begin
      state        <= state_nxt;
      seq          <= seq_nxt;
      wcnt         <= wcnt_nxt;
      tx_data      <= data_nxt;
      tx_sof_n     <= sof_nxt;
      tx_eof_n     <= eof_nxt;
      tx_src_rdy_n <= src_nxt;
      frame_cnt    <= frame_nxt;
      drop_cnt     <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_ll_tx_framer.sv
// tb/tb_ll_tx_framer.sv - self-checking bench for ll_tx_framer
`timescale 1ns/1ps
module tb_ll_tx_framer;

  localparam int P = 94;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        channel_up = 1'b1;
  logic [15:0] s_data = 16'd0;
  logic        s_valid = 1'b1;
  logic        s_ready;
  logic [15:0] tx_data;
  logic        tx_sof_n, tx_eof_n, tx_src_rdy_n;
  logic        tx_dst_rdy_n = 1'b0;
  logic [15:0] frame_cnt, drop_cnt;

  ll_tx_framer #(.PKT_WORDS(P), .DW(16)) dut (
    .clk_156m    (clk),
    .rst_n       (rst_n),
    .channel_up  (channel_up),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .tx_data     (tx_data),
    .tx_sof_n    (tx_sof_n),
    .tx_eof_n    (tx_eof_n),
    .tx_src_rdy_n(tx_src_rdy_n),
    .tx_dst_rdy_n(tx_dst_rdy_n),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: every frame attempt owns exactly P consecutive upstream words.
  logic [15:0] acc_q[$];
  logic [15:0] cur_q[$];
  int          acc_total = 0;
  int          exp_frames = 0;
  int          exp_drop = 0;
  bit          frame_open = 0;
  int          beats = 0, bubbles = 0;
  int          last_beats = 0, last_bubbles = 0;
  logic [15:0] last_hdr = 16'h0, last_eof_data = 16'h0;
  bit          drop_chk = 0, pend_flush = 0;
  int          drop_acc = 0, last_flush = -1;
  bit          stall_prev = 0;
  logic [15:0] prev_data;
  logic        prev_sof, prev_eof, prev_src;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete(); cur_q.delete();
      acc_total = 0; exp_frames = 0; exp_drop = 0;
      frame_open = 0; drop_chk = 0; pend_flush = 0; stall_prev = 0;
    end else begin
      if (drop_chk) begin
        check("abort_src_rdy", tx_src_rdy_n, 1'b1);
        drop_chk = 0;
      end
      if (stall_prev) begin
        check("stall_data", tx_data, prev_data);
        check("stall_ctl", {tx_sof_n, tx_eof_n, tx_src_rdy_n}, {prev_sof, prev_eof, prev_src});
      end
      if (!frame_open && !tx_src_rdy_n && !tx_sof_n) begin
        frame_open = 1; beats = 0; bubbles = 0; cur_q.delete();
      end
      if (frame_open && !channel_up) begin
        exp_drop++;
        frame_open = 0;
        cur_q.delete();
        drop_chk = 1;
        pend_flush = 1;
        drop_acc = acc_total;
      end else begin
        if (frame_open && tx_src_rdy_n) bubbles++;
        if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
          if (frame_open) beats++;
          if (!tx_sof_n) begin
            check("header", tx_data, {8'hA5, 8'(exp_frames)});
            check("align", 32'(acc_total % P), 32'd0);
            last_hdr = tx_data;
            if (pend_flush) begin
              last_flush = acc_total - drop_acc;
              pend_flush = 0;
            end
          end else begin
            cur_q.push_back(tx_data);
          end
          if (!tx_eof_n) begin
            check("frame_len", 32'(cur_q.size()), 32'(P));
            check("acc_len", 32'(acc_q.size() >= P), 32'd1);
            if (acc_q.size() >= P && cur_q.size() == P)
              for (int i = 0; i < P; i++)
                check("payload", cur_q[i], acc_q[acc_q.size() - P + i]);
            last_eof_data = tx_data;
            last_beats = beats;
            last_bubbles = bubbles;
            exp_frames++;
            frame_open = 0;
          end
        end
      end
      stall_prev = !tx_src_rdy_n && tx_dst_rdy_n && channel_up;
      prev_data = tx_data; prev_sof = tx_sof_n; prev_eof = tx_eof_n; prev_src = tx_src_rdy_n;
      if (s_valid && s_ready) begin
        acc_q.push_back(s_data);
        acc_total++;
        if (acc_q.size() > P) void'(acc_q.pop_front());
      end
    end
  end

  // Driver controls
  bit data_mode = 1;
  bit rand_mode = 0;
  bit toggle_dst = 0;
  int down_left = 0;

  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (rand_mode) begin
      s_valid = ($urandom_range(0, 3) != 0);
      tx_dst_rdy_n = ($urandom_range(0, 2) == 0);
      if (down_left > 0) begin
        down_left--;
        channel_up = (down_left == 0);
      end else if ($urandom_range(0, 249) == 0) begin
        down_left = $urandom_range(1, 6);
        channel_up = 1'b0;
      end
    end
    if (toggle_dst) tx_dst_rdy_n = ~tx_dst_rdy_n;
    if (data_mode) begin
      if (acc) s_data = s_data + 16'd1;
    end else begin
      s_data = 16'($urandom);
    end
  endtask

  task automatic run_until_frames(input int target, input int budget);
    int c = 0;
    while (exp_frames < target && c < budget) begin
      tick();
      c++;
    end
    check("frame_timeout", 32'(exp_frames >= target), 32'd1);
  endtask

  task automatic wait_payload(input int n, input int budget);
    int c = 0;
    while (cur_q.size() != n && c < budget) begin
      tick();
      c++;
    end
    check("payload_timeout", 32'(cur_q.size()), 32'(n));
  endtask

  initial begin
    int base;
    // Reset and basic frame with payload 0..93
    repeat (3) tick();
    check("rst_src_rdy", tx_src_rdy_n, 1'b1);
    check("rst_sof_eof", {tx_sof_n, tx_eof_n}, 2'b11);
    check("rst_data", tx_data, 16'h0000);
    check("rst_cnts", {frame_cnt, drop_cnt}, 32'h0);
    check("rst_s_ready", s_ready, 1'b0);
    rst_n = 1'b1;
    run_until_frames(1, 400);
    check("f1_beats", last_beats, 95);
    check("f1_bubbles", last_bubbles, 0);
    check("f1_hdr", last_hdr, 16'hA500);
    check("f1_eof_data", last_eof_data, 16'h005D);
    check("f1_frame_cnt", frame_cnt, 16'd1);
    repeat (3) tick();
    check("f2_hdr", last_hdr, 16'hA501);
    run_until_frames(2, 400);

    // Backpressure toggling every cycle across frame 3
    toggle_dst = 1;
    run_until_frames(3, 800);
    toggle_dst = 0;
    tx_dst_rdy_n = 1'b0;
    check("f3_beats", last_beats, 95);

    // Three-cycle upstream gap inside frame 4
    wait_payload(20, 400);
    s_valid = 1'b0;
    repeat (3) tick();
    s_valid = 1'b1;
    run_until_frames(4, 400);
    check("f4_bubbles", last_bubbles, 3);
    check("f4_beats", last_beats, 95);

    // Channel loss after 40 payload words of frame 5
    wait_payload(39, 400);
    channel_up = 1'b0;
    repeat (3) tick();
    channel_up = 1'b1;
    run_until_frames(5, 600);
    check("flush_words", last_flush, 54);
    check("drop_cnt_1", drop_cnt, 16'd1);
    check("seq_reuse_hdr", last_hdr, 16'hA504);
    check("frame_cnt_5", frame_cnt, 16'd5);

    // Randomized traffic with backpressure, gaps and channel drops
    data_mode = 0;
    rand_mode = 1;
    repeat (5000) tick();
    rand_mode = 0;
    channel_up = 1'b1; s_valid = 1'b1; tx_dst_rdy_n = 1'b0; down_left = 0;
    base = exp_frames;
    run_until_frames(base + 2, 1000);
    check("rand_frame_cnt", frame_cnt, 16'(exp_frames));
    check("rand_drop_cnt", drop_cnt, 16'(exp_drop));

    // Channel down at reset release, then 256 back-to-back frames
    rst_n = 1'b0;
    channel_up = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("chdown_s_ready", s_ready, 1'b0);
      check("chdown_src_rdy", tx_src_rdy_n, 1'b1);
    end
    channel_up = 1'b1;
    tick();
    check("chup_hdr_ctl", {tx_sof_n, tx_src_rdy_n}, 2'b00);
    check("chup_hdr_data", tx_data, 16'hA500);
    run_until_frames(256, 256 * 110);
    check("frame_cnt_256", frame_cnt, 16'd256);
    repeat (3) tick();
    check("seq_wrap_hdr", last_hdr, 16'hA500);

    // Asynchronous reset mid-frame
    wait_payload(10, 400);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {tx_sof_n, tx_eof_n, tx_src_rdy_n, s_ready}, 4'b1110);
    check("mid_rst_data", tx_data, 16'h0000);
    check("mid_rst_cnts", {frame_cnt, drop_cnt}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_until_frames(1, 400);
    check("post_rst_frame_cnt", frame_cnt, 16'd1);
    check("post_rst_hdr", last_hdr, 16'hA500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
